// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared register map, bit indices and FSM encoding for the CRC stream peripheral
package crc_pkg;

  localparam logic [1:0] CRC_REG_DATA   = 2'd0;
  localparam logic [1:0] CRC_REG_CTRL   = 2'd1;
  localparam logic [1:0] CRC_REG_RESULT = 2'd2;

  localparam int CTRL_INIT   = 0;
  localparam int CTRL_XOROUT = 1;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_FULL     = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_COUNT    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } crc_state_e;

  localparam logic [15:0] CRC16_CCITT = 16'h1021;
  localparam logic [7:0]  CRC8_ATM    = 8'h07;

endpackage

// File: rtl/crc_byte_fifo.sv
// rtl/crc_byte_fifo.sv - byte FIFO with registered pointers and a count one bit wider than the pointers
module crc_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/crc_stream_peripheral.sv
// rtl/crc_stream_peripheral.sv - MMIO CRC peripheral: byte FIFO feeding a bit-serial MSB-first CRC engine
module crc_stream_peripheral
  import crc_pkg::*;
#(
  parameter int               CRC_W      = 16,
  parameter logic [CRC_W-1:0] POLY       = CRC16_CCITT,
  parameter logic [CRC_W-1:0] INIT       = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOROUT     = 16'hFFFF,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  input  logic        wr_en,
  output logic [31:0] data_out,
  output logic        irq_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  crc_state_e       state;
  crc_state_e       next_state;
  logic [CRC_W-1:0] crc;
  logic [CRC_W-1:0] crc_shifted;
  logic [7:0]       sreg;
  logic [2:0]       cnt;
  logic             overflow;
  logic             xorout_en;
  logic             seen;
  logic             fb;
  logic             busy;

  logic             wr_data;
  logic             wr_ctrl;
  logic             do_init;
  logic             fifo_rst_n;
  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             unused_data_in;

  assign wr_data        = wr_en && (addr == CRC_REG_DATA);
  assign wr_ctrl        = wr_en && (addr == CRC_REG_CTRL);
  assign do_init        = wr_ctrl && data_in[CTRL_INIT];
  assign unused_data_in = ^data_in[31:8];

  // An init write empties the FIFO through its synchronous reset.
  assign fifo_rst_n = rst_n && !do_init;
  assign fifo_push  = wr_data && !fifo_full;
  assign fifo_pop   = (state == IDLE) && !fifo_empty && !do_init;

  crc_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (fifo_rst_n),
    .push  (fifo_push),
    .din   (data_in[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fb          = crc[CRC_W-1] ^ sreg[7];
  assign crc_shifted = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign busy        = (state == SHIFT) || !fifo_empty;
  assign irq_done    = (state == IDLE) && fifo_empty && seen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_empty) next_state = SHIFT;
      SHIFT:   if (cnt == 3'd7) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (do_init) begin
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc       <= INIT;
      sreg      <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      xorout_en <= 1'b0;
      seen      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        xorout_en <= data_in[CTRL_XOROUT];
      end
      if (do_init) begin
        crc      <= INIT;
        cnt      <= '0;
        overflow <= 1'b0;
        seen     <= 1'b0;
      end else begin
        if (wr_data && fifo_full) begin
          overflow <= 1'b1;
        end
        if (fifo_pop) begin
          sreg <= fifo_dout;
          cnt  <= '0;
        end else if (state == SHIFT) begin
          crc  <= crc_shifted;
          sreg <= {sreg[6:0], 1'b0};
          cnt  <= cnt + 1'b1;
          if (cnt == 3'd7) begin
            seen <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    data_out = '0;
    case (addr)
      CRC_REG_CTRL: begin
        data_out[STAT_BUSY]          = busy;
        data_out[STAT_EMPTY]         = fifo_empty;
        data_out[STAT_FULL]          = fifo_full;
        data_out[STAT_OVERFLOW]      = overflow;
        data_out[STAT_COUNT +: CW]   = fifo_count;
      end
      CRC_REG_RESULT: data_out[CRC_W-1:0] = crc ^ (xorout_en ? XOROUT : '0);
      default:        data_out = '0;
    endcase
  end

endmodule
